// File: rtl/kbd_pkg.sv
// Shared keyboard-scan types: slot count, scancode/table types and differ state.
// Also used by the downstream arbiter stage.
package kbd_pkg;
    localparam int KBD_NUM_SLOTS = 14;
    localparam int KBD_PTR_W     = 4;

    typedef logic [8:0] scancode_t;
    typedef scancode_t [KBD_NUM_SLOTS-1:0] slot_table_t;

    typedef enum logic [1:0] {
        COLLECT,
        BREAK,
        MAKE,
        COMMIT
    } kbd_state_t;

    // Enables table entries strictly below index p (earlier-duplicate suppression).
    function automatic logic [KBD_NUM_SLOTS-1:0] below_mask(input logic [KBD_PTR_W-1:0] p);
        logic [KBD_NUM_SLOTS-1:0] m;
        for (int i = 0; i < KBD_NUM_SLOTS; i++) begin
            m[i] = (i < int'(p));
        end
        return m;
    endfunction
endpackage

// File: rtl/key_slot_match.sv
// Purpose: flags whether a 9-bit code appears in any enabled entry of a slot table.
// Latency: combinational. Backpressure: none.
module key_slot_match
    import kbd_pkg::*;
(
    input  scancode_t                i_code,
    input  slot_table_t              i_table,
    input  logic [KBD_NUM_SLOTS-1:0] i_mask,
    output logic                     o_hit
);
    always_comb begin
        o_hit = 1'b0;
        for (int i = 0; i < KBD_NUM_SLOTS; i++) begin
            if (i_mask[i] && (i_table[i] == i_code)) begin
                o_hit = 1'b1;
            end
        end
    end
endmodule

// File: rtl/key_frame_diff.sv
// Purpose: diffs each 14-slot key frame against held keys, emitting break then make events.
// Latency: 29 cycles per frame plus consumer stalls. Backpressure: busy holds off upstream; events wait on event_ready.
module key_frame_diff
    import kbd_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic [3:0] key_idx,
    input  scancode_t scancode,
    output logic      busy,
    output logic      event_valid,
    input  logic      event_ready,
    output scancode_t event_code,
    output logic      event_pressed
);
    kbd_state_t             r_state;
    logic [KBD_PTR_W-1:0]   r_ptr;
    logic [3:0]             r_key_idx_q;
    slot_table_t            r_cur;
    slot_table_t            r_prev;

    logic        w_collect;
    logic        w_in_break;
    logic        w_scan;
    logic        w_frame_end;
    logic        w_discard;
    logic        w_load;
    scancode_t   w_code;
    slot_table_t w_cross_tbl;
    slot_table_t w_self_tbl;
    logic        w_cross_hit;
    logic        w_self_hit;
    logic        w_qual;
    logic        w_adv;
    logic        w_last;

    assign w_collect   = (r_state == COLLECT);
    assign w_in_break  = (r_state == BREAK);
    assign w_scan      = (r_state == BREAK) || (r_state == MAKE);
    assign w_frame_end = w_collect && (r_key_idx_q == 4'd14) && (key_idx == 4'd0);
    assign w_discard   = w_collect && (key_idx == 4'd0) &&
                         (r_key_idx_q != 4'd0) && (r_key_idx_q != 4'd14);
    assign w_load      = w_collect && (key_idx != r_key_idx_q) &&
                         (key_idx >= 4'd1) && (key_idx <= 4'd14);

    // BREAK looks for held keys missing from the new frame; MAKE the reverse.
    assign w_code      = w_in_break ? r_prev[r_ptr] : r_cur[r_ptr];
    assign w_cross_tbl = w_in_break ? r_cur : r_prev;
    assign w_self_tbl  = w_in_break ? r_prev : r_cur;

    key_slot_match u_cross_match (
        .i_code  (w_code),
        .i_table (w_cross_tbl),
        .i_mask  ({KBD_NUM_SLOTS{1'b1}}),
        .o_hit   (w_cross_hit)
    );

    key_slot_match u_self_match (
        .i_code  (w_code),
        .i_table (w_self_tbl),
        .i_mask  (below_mask(r_ptr)),
        .o_hit   (w_self_hit)
    );

    assign w_qual = w_scan && (w_code != '0) && !w_cross_hit && !w_self_hit;
    assign w_adv  = !w_qual || event_ready;
    assign w_last = (r_ptr == KBD_PTR_W'(KBD_NUM_SLOTS - 1));

    assign busy          = !w_collect || w_frame_end;
    assign event_valid   = w_qual;
    assign event_code    = w_qual ? w_code : '0;
    assign event_pressed = w_qual && (r_state == MAKE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= COLLECT;
            r_ptr       <= '0;
            r_key_idx_q <= '0;
            r_cur       <= '0;
            r_prev      <= '0;
        end else begin
            r_key_idx_q <= key_idx;
            case (r_state)
                COLLECT: begin
                    if (w_frame_end) begin
                        r_state <= BREAK;
                        r_ptr   <= '0;
                    end else if (w_discard) begin
                        r_cur <= '0;
                    end else if (w_load) begin
                        r_cur[key_idx - 4'd1] <= scancode;
                    end
                end
                BREAK, MAKE: begin
                    if (w_adv) begin
                        if (w_last) begin
                            r_ptr   <= '0;
                            r_state <= w_in_break ? MAKE : COMMIT;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    r_prev  <= r_cur;
                    r_ptr   <= '0;
                    r_state <= COLLECT;
                end
                default: r_state <= COLLECT;
            endcase
        end
    end
endmodule
